pmem_arbiter: RTL and testbench

// - Shares one 256-bit physical-memory port between the instruction cache (port I) and data cache (port D).
// - Sits between both caches' pmem_* sides and the cacheline adaptor/main memory; one line transaction in flight at a time.
// - Fixed priority D > I, with an optional starvation guard for I.

---
 rtl/pmem_arbiter_pkg.sv | 25 ++
 rtl/pmem_arbiter.sv | 129 ++++++++++++
 tb/tb_pmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D physical-memory arbiter: FSM states, requester ids
// and the fixed-priority pick helper.
package pmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE
  } pmem_arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } pmem_req_id_t;

  localparam int PMEM_ARB_ADDR_W = 32;
  localparam int PMEM_ARB_LINE_W = 256;

  // D wins unless the starvation guard forces I; only meaningful when someone requests.
  function automatic pmem_req_id_t pick_requester(input logic d_req, input logic i_force);
    return (d_req && !i_force) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Two-requester (I-cache, D-cache) arbiter for a single 256-bit line memory port.
// Optional I starvation guard enabled with `define PMEM_ARB_STARVE_EN.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = PMEM_ARB_ADDR_W,
  parameter int LINE_W = PMEM_ARB_LINE_W
`ifdef PMEM_ARB_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t r_state;
  pmem_arb_state_t w_state_next;
  pmem_req_id_t    w_pick;
  logic            w_d_req;
  logic            w_force_i;

  assign w_d_req = d_read | d_write;
  assign w_pick  = pick_requester(w_d_req, w_force_i);

`ifdef PMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_i = i_read && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts D wins while I was waiting; any I grant clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_state_next == GNT_I) begin
        r_starve_cnt <= '0;
      end else if (w_state_next == GNT_D && i_read &&
                   r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_d_req || i_read) begin
          w_state_next = (w_pick == REQ_D) ? GNT_D : GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (pmem_resp) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Memory side follows the granted requester's live inputs; a D write masks a D read.
  always_comb begin
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    unique case (r_state)
      GNT_I: begin
        pmem_address = i_address;
        pmem_read    = i_read;
        i_resp       = pmem_resp;
        if (pmem_resp) begin
          i_rdata = pmem_rdata;
        end
      end
      GNT_D: begin
        pmem_address = d_address;
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) begin
          d_rdata = pmem_rdata;
        end
      end
      default: ;
    endcase
  end

  a_i_held: assert property (@(posedge clk) disable iff (!rst)
                             (r_state == GNT_I) |-> i_read);
  a_d_held: assert property (@(posedge clk) disable iff (!rst)
                             (r_state == GNT_D) |-> (d_read || d_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised bench for pmem_arbiter: a cycle-level reference model predicts grants,
// memory traffic and responses; a negedge monitor checks them against the DUT.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef PMEM_ARB_STARVE_EN
  localparam int LIMIT = 4;
  int starve = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_read = 1'b0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic [AW-1:0] d_address = '0;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester agents
  bit            ip = 0, i_done = 0;
  logic [AW-1:0] ia = '0;
  bit            dp = 0, drd = 0, dwr = 0, d_done = 0;
  logic [AW-1:0] da = '0;
  logic [LW-1:0] dwd = '0;
  int            i_rate = 0, d_rate = 0, lat_min = 0, lat_max = 0;
  bit            stray_en = 0, d_cont = 0;

  // Reference model of the shared port
  bit            busy = 0, owner_d = 0, in_reset = 1;
  bit            rst_cmd_assert = 0, rst_cmd_release = 0;
  int            resp_at = 0, decide_at = 0;
  bit            g_rd = 0, g_wr = 0;
  logic [AW-1:0] g_addr = '0;
  logic [LW-1:0] g_wdata = '0;

  // Expected memory-side view for the current cycle
  bit            e_act = 0, e_rd = 0, e_wr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [LW-1:0] e_wdata = '0;

  typedef struct {
    int            cyc;
    bit            is_d;
    logic [LW-1:0] rdata;
  } resp_t;
  resp_t resp_q[$];

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_d();
    int kind;
    kind = $urandom_range(2);
    dp  = 1;
    drd = (kind != 1);
    dwr = (kind != 0);
    da  = $urandom;
    dwd = rand_line();
  endtask

  // One clock: update agents, play memory, then arbitrate from the requests visible this cycle.
  task automatic step();
    logic [LW-1:0] r;
    bit pick_i;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_cmd_assert) begin
      rst = 0; in_reset = 1; busy = 0; rst_cmd_assert = 0;
`ifdef PMEM_ARB_STARVE_EN
      starve = 0;
`endif
    end else if (rst_cmd_release) begin
      rst = 1; in_reset = 0; decide_at = cyc; rst_cmd_release = 0;
    end

    if (i_done) begin ip = 0; i_done = 0; end
    if (d_done) begin dp = 0; d_done = 0; end
    if (!ip && $urandom_range(99) < i_rate) begin ip = 1; ia = $urandom; end
    if (!dp && (d_cont || $urandom_range(99) < d_rate)) new_d();
    i_read    = ip;
    i_address = ip ? ia : $urandom;
    d_read    = dp & drd;
    d_write   = dp & dwr;
    d_address = dp ? da : $urandom;
    d_wdata   = dp ? dwd : rand_line();

    e_act = busy; e_rd = g_rd; e_wr = g_wr; e_addr = g_addr; e_wdata = g_wdata;

    pmem_resp  = 0;
    pmem_rdata = rand_line();
    if (busy && cyc >= resp_at) begin
      r = rand_line();
      pmem_resp  = 1;
      pmem_rdata = r;
      resp_q.push_back('{cyc, owner_d, r});
      busy = 0;
      decide_at = cyc + 2;
      if (owner_d) d_done = 1; else i_done = 1;
    end else if (!busy && stray_en && $urandom_range(7) == 0) begin
      pmem_resp = 1;
    end

    if (!busy && !in_reset && cyc >= decide_at && (ip || dp)) begin
`ifdef PMEM_ARB_STARVE_EN
      pick_i = ip && (!dp || starve == LIMIT);
`else
      pick_i = !dp;
`endif
      if (pick_i) begin
        owner_d = 0; g_addr = ia; g_rd = 1; g_wr = 0; g_wdata = '0;
`ifdef PMEM_ARB_STARVE_EN
        starve = 0;
`endif
      end else begin
        owner_d = 1; g_addr = da; g_wr = dwr; g_rd = !dwr; g_wdata = dwd;
`ifdef PMEM_ARB_STARVE_EN
        if (ip && starve < LIMIT) starve++;
`endif
      end
      busy = 1;
      resp_at = cyc + 1 + $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((ip || dp || busy || i_done || d_done) && n < budget) begin
      step();
      n++;
    end
    chk(!(ip || dp || busy), "drain_timeout", LW'(n), LW'(budget));
    repeat (2) step();
  endtask

  // Monitor: memory-side view every cycle, responses popped from the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk(pmem_read == (e_act && e_rd), "pmem_read", LW'(pmem_read), LW'(e_act && e_rd));
        chk(pmem_write == (e_act && e_wr), "pmem_write", LW'(pmem_write), LW'(e_act && e_wr));
        if (e_act) begin
          chk(pmem_address == e_addr, "pmem_address", LW'(pmem_address), LW'(e_addr));
          if (e_wr) chk(pmem_wdata == e_wdata, "pmem_wdata", pmem_wdata, e_wdata);
        end else begin
          chk(pmem_address == '0, "pmem_address_idle", LW'(pmem_address), '0);
          chk(pmem_wdata == '0, "pmem_wdata_idle", pmem_wdata, '0);
        end
        if (i_resp || d_resp || (resp_q.size() > 0 && resp_q[0].cyc <= cyc)) begin
          if (resp_q.size() == 0) begin
            chk(0, "unexpected_resp", LW'({i_resp, d_resp}), '0);
          end else begin
            e = resp_q.pop_front();
            chk(e.cyc == cyc, "resp_cycle", LW'(cyc), LW'(e.cyc));
            chk(i_resp == !e.is_d && d_resp == e.is_d, "resp_port",
                LW'({i_resp, d_resp}), LW'({!e.is_d, e.is_d}));
            chk((e.is_d ? d_rdata : i_rdata) == e.rdata, "resp_rdata",
                e.is_d ? d_rdata : i_rdata, e.rdata);
            chk((e.is_d ? i_rdata : d_rdata) == '0, "other_rdata_zero",
                e.is_d ? i_rdata : d_rdata, '0);
            $display("txn cycle=%0d port=%s rdata=%0h", cyc, e.is_d ? "D" : "I", e.rdata);
          end
        end else begin
          chk(i_rdata == '0 && d_rdata == '0 && !i_resp && !d_resp, "no_resp_zero",
              i_rdata | d_rdata, '0);
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    rst_cmd_release = 1;
    step();

    // I read alone, memory answers 4 cycles into the grant
    lat_min = 4; lat_max = 4;
    ip = 1; ia = 32'h0000_1000;
    run_until_idle(50);

    // I and D write together: D first, then I after the dead cycle
    lat_min = 0; lat_max = 3;
    ip = 1; ia = $urandom;
    dp = 1; drd = 0; dwr = 1; da = 32'h0000_2000; dwd = rand_line();
    run_until_idle(50);

    // D read and write together: write only
    dp = 1; drd = 1; dwr = 1; da = $urandom; dwd = rand_line();
    run_until_idle(50);

    // Continuous D traffic with I waiting
    ip = 1; ia = $urandom; d_cont = 1;
    repeat (40) step();
    d_cont = 0;
    run_until_idle(100);

    // Reset in the middle of a D read grant
    lat_min = 3; lat_max = 3;
    dp = 1; drd = 1; dwr = 0; da = $urandom; dwd = rand_line();
    for (int n = 0; n < 10 && !(busy && e_act); n++) step();
    rst_cmd_assert = 1;
    step();
    step();
    rst_cmd_release = 1;
    run_until_idle(50);

    // Stray memory responses while idle, then a normal I read
    stray_en = 1;
    repeat (12) step();
    ip = 1; ia = $urandom;
    run_until_idle(50);

    // Random mixed traffic with occasional resets
    lat_min = 0; lat_max = 3; i_rate = 30; d_rate = 40;
    for (int n = 0; n < 3000; n++) begin
      if (in_reset) rst_cmd_release = 1;
      else if ($urandom_range(399) == 0) rst_cmd_assert = 1;
      step();
    end
    if (in_reset) rst_cmd_release = 1;
    i_rate = 0; d_rate = 0; stray_en = 0;
    run_until_idle(200);
    repeat (3) step();
    chk(resp_q.size() == 0, "resp_queue_drained", LW'(resp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
